instr_fetch_buffer: RTL and testbench

Parametrised instruction fetch stage: a word-addressed, synchronous-read instruction memory with its own fetch PC and a small prefetch FIFO, presenting instruction and PC to decode over a valid/ready handshake. Supports branch/jump redirect with flush and a write port for program loading. It sits between the PC/branch logic and decode, and replaces the combinational instruction memory.

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_sync_ram.sv | 33 +++
 rtl/instr_fetch_buffer.sv | 127 ++++++++++++
 tb/tb_instr_fetch_buffer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction fetch stage.
package imem_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_ADDR_W = 11;
    localparam int unsigned DEF_PC_W   = 32;

    // All-zero word decodes as NOP; also what out_instr shows when idle.
    localparam logic [DEF_DATA_W-1:0] NOP_INSTR = '0;

    // Prefetch FIFO entry at the default widths.
    typedef struct packed {
        logic [DEF_PC_W-1:0]   pc;
        logic [DEF_DATA_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/imem_sync_ram.sv
// Instruction memory: one synchronous read port, one write port,
// read returns the old word when it collides with a write.
module imem_sync_ram
    import imem_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter string       INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata
);

    localparam int unsigned WORDS = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [WORDS];

    // Non-blocking update gives read-old-data on a same-address collision.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Fetch stage: fetch PC, credit-based read issue and a prefetch FIFO
// presenting {pc, instr} to decode over valid/ready.
module instr_fetch_buffer
    import imem_pkg::*;
#(
    parameter int unsigned     DATA_W    = DEF_DATA_W,
    parameter int unsigned     ADDR_W    = DEF_ADDR_W,
    parameter int unsigned     PC_W      = DEF_PC_W,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0,
    parameter string           INIT_FILE = ""
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect_valid,
    input  logic [PC_W-1:0]            redirect_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_instr,
    output logic [PC_W-1:0]            out_pc,
    output logic [PC_W-1:0]            out_next_pc,
    input  logic                       imem_we,
    input  logic [ADDR_W-1:0]          imem_waddr,
    input  logic [DATA_W-1:0]          imem_wdata,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Same layout as fetch_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    logic [PC_W-1:0]   fetch_pc;
    logic              pending;
    logic [PC_W-1:0]   pend_pc;
    entry_t            fifo_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] rdata;

    logic              issue_c;
    logic              push_c;
    logic              pop_c;
    logic [PC_W-1:0]   issue_pc_c;
    entry_t            head_c;

    // Issue/push/pop decisions; redirect overrides the credit check and flushes.
    always_comb begin
        issue_c    = redirect_valid || ((32'(count) + 32'(pending)) < DEPTH);
        issue_pc_c = redirect_valid ? redirect_pc : fetch_pc;
        push_c     = pending && !redirect_valid;
        pop_c      = (count != '0) && out_ready && !redirect_valid;
        head_c     = fifo_q[rd_ptr];
    end

    imem_sync_ram #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .re    (issue_c),
        .raddr (issue_pc_c[ADDR_W-1:0]),
        .rdata (rdata),
        .we    (imem_we),
        .waddr (imem_waddr),
        .wdata (imem_wdata)
    );

    // Fetch PC, in-flight read tracking and FIFO pointers/occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc <= RESET_PC;
            pending  <= 1'b0;
            pend_pc  <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            pending <= issue_c;
            if (issue_c) begin
                pend_pc  <= issue_pc_c;
                fetch_pc <= issue_pc_c + PC_W'(1);
            end
            if (redirect_valid) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push_c) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop_c) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                count <= count + CNT_W'(push_c) - CNT_W'(pop_c);
            end
        end
    end

    // FIFO payload storage; validity is tracked by count alone.
    always_ff @(posedge clk) begin
        if (push_c) begin
            fifo_q[wr_ptr] <= '{pc: pend_pc, instr: rdata};
        end
    end

    // Head presentation, zeroed while the FIFO is empty.
    always_comb begin
        out_valid   = (count != '0);
        out_instr   = DATA_W'(NOP_INSTR);
        out_pc      = '0;
        out_next_pc = '0;
        if (out_valid) begin
            out_instr   = head_c.instr;
            out_pc      = head_c.pc;
            out_next_pc = head_c.pc + PC_W'(1);
        end
        fifo_count = count;
    end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Directed bench for instr_fetch_buffer with hand-computed expectations.
module tb_instr_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_next_pc;
    logic        imem_we;
    logic [10:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    instr_fetch_buffer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .out_next_pc    (out_next_pc),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .fifo_count     (fifo_count)
    );

    always #5 clk = ~clk;

    // Image word loaded at small addresses.
    function automatic logic [31:0] w(input int i);
        return 32'hA5A5_0000 + 32'(i);
    endfunction

    localparam logic [31:0] W20  = 32'h2020_0020;
    localparam logic [31:0] W21  = 32'h2121_0021;
    localparam logic [31:0] W7FF = 32'h7FF0_0BAD;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_word(input logic [10:0] a, input logic [31:0] d);
        imem_we    = 1'b1;
        imem_waddr = a;
        imem_wdata = d;
        step();
        imem_we    = 1'b0;
    endtask

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        imem_we        = 1'b0;
        imem_waddr     = '0;
        imem_wdata     = '0;

        // Program load while held in reset.
        for (int i = 0; i < 8; i++) write_word(11'(i), w(i));
        write_word(11'h020, W20);
        write_word(11'h021, W21);
        write_word(11'h7FF, W7FF);

        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(fifo_count), 64'd0);
        check("rst_pc", 64'(out_pc), 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);
        check("rst_next_pc", 64'(out_next_pc), 64'd0);

        // Streaming from reset with decode always ready.
        out_ready = 1'b1;
        rst_n     = 1'b1;
        step();
        check("edge1_valid", 64'(out_valid), 64'd0);
        step();
        for (int i = 0; i < 4; i++) begin
            check("stream_valid", 64'(out_valid), 64'd1);
            check("stream_pc", 64'(out_pc), 64'(i));
            check("stream_instr", 64'(out_instr), 64'(w(i)));
            check("stream_next_pc", 64'(out_next_pc), 64'(i + 1));
            step();
        end

        // Backpressure from reset: fill to DEPTH, then drain without bubbles.
        rst_n     = 1'b0;
        out_ready = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("full_count", 64'(fifo_count), 64'd4);
        check("full_head_pc", 64'(out_pc), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("drain_valid", 64'(out_valid), 64'd1);
            check("drain_pc", 64'(out_pc), 64'(i));
            check("drain_instr", 64'(out_instr), 64'(w(i)));
            step();
        end

        // Redirect with three entries buffered.
        out_ready = 1'b0;
        step();
        check("pre_redir_count", 64'(fifo_count), 64'd3);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        step();
        redirect_valid = 1'b0;
        check("redir_flush_valid", 64'(out_valid), 64'd0);
        check("redir_flush_count", 64'(fifo_count), 64'd0);
        check("redir_flush_pc", 64'(out_pc), 64'd0);
        out_ready = 1'b1;
        step();
        check("redir_pc0", 64'(out_pc), 64'h20);
        check("redir_instr0", 64'(out_instr), 64'(W20));
        step();
        check("redir_pc1", 64'(out_pc), 64'h21);
        check("redir_instr1", 64'(out_instr), 64'(W21));

        // Memory index wraps at 2**ADDR_W while the PC keeps counting.
        redirect_valid = 1'b1;
        redirect_pc    = 32'd2047;
        step();
        redirect_valid = 1'b0;
        step();
        check("wrap_pc_a", 64'(out_pc), 64'd2047);
        check("wrap_instr_a", 64'(out_instr), 64'(W7FF));
        check("wrap_next_a", 64'(out_next_pc), 64'd2048);
        step();
        check("wrap_pc_b", 64'(out_pc), 64'd2048);
        check("wrap_instr_b", 64'(out_instr), 64'(w(0)));
        check("wrap_next_b", 64'(out_next_pc), 64'd2049);

        // Write port, then same-edge read/write collision returns old word.
        write_word(11'd5, 32'hDEADBEEF);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd5;
        step();
        redirect_valid = 1'b0;
        step();
        check("wr_pc", 64'(out_pc), 64'd5);
        check("wr_instr", 64'(out_instr), 64'hDEADBEEF);

        redirect_valid = 1'b1;
        redirect_pc    = 32'd5;
        imem_we        = 1'b1;
        imem_waddr     = 11'd5;
        imem_wdata     = 32'h1234_5678;
        step();
        redirect_valid = 1'b0;
        imem_we        = 1'b0;
        step();
        check("coll_pc", 64'(out_pc), 64'd5);
        check("coll_old_instr", 64'(out_instr), 64'hDEADBEEF);

        redirect_valid = 1'b1;
        redirect_pc    = 32'd5;
        step();
        redirect_valid = 1'b0;
        step();
        check("coll_new_instr", 64'(out_instr), 64'h1234_5678);

        // Asynchronous reset with a read pending and two entries buffered.
        out_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h20;
        step();
        redirect_valid = 1'b0;
        step();
        step();
        check("pre_rst_count", 64'(fifo_count), 64'd2);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_count", 64'(fifo_count), 64'd0);
        step();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();
        check("restart_edge1_valid", 64'(out_valid), 64'd0);
        step();
        check("restart_valid", 64'(out_valid), 64'd1);
        check("restart_pc", 64'(out_pc), 64'd0);
        check("restart_instr", 64'(out_instr), 64'(w(0)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
